// File: rtl/snn_pkg.sv
// Shared types and arithmetic for the spiking-neuron layer datapath.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package snn_pkg;

  // Membrane-voltage width, signed two's complement.
  localparam int VW = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CMP,
    EMIT,
    DONE
  } fire_state_t;

  // v - t computed one bit wider, then clamped back into the signed VW-bit range.
  function automatic logic signed [VW-1:0] sat_sub(input logic signed [VW-1:0] v,
                                                   input logic signed [VW-1:0] t);
    logic signed [VW:0] d;
    d = {v[VW-1], v} - {t[VW-1], t};
    if (d[VW] != d[VW-1]) begin
      sat_sub = d[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
    end else begin
      sat_sub = d[VW-1:0];
    end
  endfunction

endpackage

// File: rtl/spike_fire_ctrl_if.sv
// Voltage-bank port plus the outgoing spike-index stream of the fire stage.
// Latency: n/a (wiring only).
// Backpressure: spike stream is valid/ready; the bank port has none.
interface spike_fire_ctrl_if #(
  parameter int VW = 16,
  parameter int AW = 4
);
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic signed [VW-1:0] mem_rd_data;
  logic                 mem_wr_en;
  logic signed [VW-1:0] mem_wr_data;
  logic                 spike_valid;
  logic                 spike_ready;
  logic [AW-1:0]        spike_idx;

  modport master (
    output mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, spike_valid, spike_idx,
    input  mem_rd_data, spike_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, spike_valid, spike_idx,
    output mem_rd_data, spike_ready
  );
endinterface

// File: rtl/fire_reset_calc.sv
// Threshold compare and reset-voltage selection for one neuron.
// Latency: combinational.
// Backpressure: none.
module fire_reset_calc
  import snn_pkg::*;
#(
  parameter int RESET_MODE = 0
) (
  input  logic signed [VW-1:0] v_i,
  input  logic signed [VW-1:0] t_i,
  output logic                 fire_o,
  output logic signed [VW-1:0] rst_val_o
);

  // Signed compare; mode 0 keeps the residue above threshold, mode 1 clears it.
  always_comb begin
    fire_o    = (v_i >= t_i);
    rst_val_o = (RESET_MODE != 0) ? '0 : sat_sub(v_i, t_i);
  end

endmodule

// File: rtl/spike_fire_ctrl.sv
// Scans the membrane bank, writes back reset voltages and emits spike indices.
// Latency: 2 cycles per quiet neuron, 3 per firing neuron, plus spike stall.
// Backpressure: scan holds in EMIT with index stable until spike_ready.
module spike_fire_ctrl
  import snn_pkg::*;
#(
  parameter int N_NEURON   = 16,
  parameter int AW         = $clog2(N_NEURON),
  parameter int RESET_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic signed [VW-1:0] thresh_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AW:0]          spike_count_o,
  spike_fire_ctrl_if.master    bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURON - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  fire_state_t          state_q;
  logic signed [VW-1:0] thr_q;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        idx_q;
  logic [AW:0]          cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_en_q;
  logic                 vld_q;

  logic [AW-1:0]        addr_d;
  logic [AW:0]          cnt_d;
  logic                 last;
  logic                 fire;
  logic signed [VW-1:0] rst_val;

  fire_reset_calc #(
    .RESET_MODE (RESET_MODE)
  ) u_calc (
    .v_i       (bus.mem_rd_data),
    .t_i       (thr_q),
    .fire_o    (fire),
    .rst_val_o (rst_val)
  );

  assign addr_d = addr_q + ADDR_ONE;
  assign cnt_d  = cnt_q + CNT_ONE;
  assign last   = (addr_q == LAST_IDX);

  // Scan sequencer; the bank address doubles as the neuron index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      thr_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            thr_q   <= thresh_i;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          rd_en_q <= 1'b0;
          state_q <= CMP;
        end
        CMP: begin
          if (fire) begin
            vld_q   <= 1'b1;
            idx_q   <= addr_q;
            state_q <= EMIT;
          end else if (last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_d;
            rd_en_q <= 1'b1;
            state_q <= RD;
          end
        end
        EMIT: begin
          if (bus.spike_ready) begin
            vld_q <= 1'b0;
            cnt_q <= cnt_d;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_d;
              rd_en_q <= 1'b1;
              state_q <= RD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data only arrives in CMP, so the write strobe is qualified there by the
  // compare result; it still completes one cycle before the spike is offered.
  assign bus.mem_wr_en   = (state_q == CMP) && fire;
  assign bus.mem_wr_data = bus.mem_wr_en ? rst_val : '0;

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.spike_valid = vld_q;
  assign bus.spike_idx   = idx_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign spike_count_o   = cnt_q;

endmodule

// File: tb/tb_spike_fire_ctrl.sv
// Directed bench for spike_fire_ctrl: bank model, write/spike logs, per-scenario checks.
// Cycle counts include the cycle in which start is asserted.
// Spike stalls are produced by dropping spike_ready while a spike is offered.
module tb_spike_fire_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start0 = 1'b0;
  logic               start1 = 1'b0;
  logic signed [15:0] thresh0 = '0;
  logic signed [15:0] thresh1 = '0;
  logic               busy0, done0, busy1, done1;
  logic [4:0]         cnt0, cnt1;
  logic               ready0 = 1'b1;

  spike_fire_ctrl_if #(.VW(16), .AW(4)) bus0 ();
  spike_fire_ctrl_if #(.VW(16), .AW(4)) bus1 ();

  assign bus0.spike_ready = ready0;
  assign bus1.spike_ready = 1'b1;

  spike_fire_ctrl #(.N_NEURON(16), .AW(4), .RESET_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .thresh_i(thresh0),
    .busy_o(busy0), .done_o(done0), .spike_count_o(cnt0), .bus(bus0)
  );

  spike_fire_ctrl #(.N_NEURON(16), .AW(4), .RESET_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .thresh_i(thresh1),
    .busy_o(busy1), .done_o(done1), .spike_count_o(cnt1), .bus(bus1)
  );

  logic signed [15:0] bank0 [16];
  logic signed [15:0] bank1 [16];
  int                 wr_addr0 [$];
  logic signed [15:0] wr_dat0 [$];
  int                 spk0 [$];
  int                 wr_addr1 [$];
  logic signed [15:0] wr_dat1 [$];

  int n_cmp = 0;
  int n_err = 0;
  int busy_low = 0;

  // Bank model: registered read, write applied at the clock edge; logs every write and handshake.
  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rd_data <= bank0[bus0.mem_addr];
    if (bus1.mem_rd_en) bus1.mem_rd_data <= bank1[bus1.mem_addr];
    if (bus0.mem_wr_en) begin
      bank0[bus0.mem_addr] = bus0.mem_wr_data;
      wr_addr0.push_back(int'(bus0.mem_addr));
      wr_dat0.push_back(bus0.mem_wr_data);
    end
    if (bus1.mem_wr_en) begin
      bank1[bus1.mem_addr] = bus1.mem_wr_data;
      wr_addr1.push_back(int'(bus1.mem_addr));
      wr_dat1.push_back(bus1.mem_wr_data);
    end
    if (bus0.spike_valid && bus0.spike_ready) spk0.push_back(int'(bus0.spike_idx));
  end

  task automatic load_banks(input logic signed [15:0] base, input int ia,
                            input logic signed [15:0] va, input int ib,
                            input logic signed [15:0] vb);
    for (int k = 0; k < 16; k++) begin
      bank0[k] = base;
      bank1[k] = base;
    end
    if (ia >= 0) begin bank0[ia] = va; bank1[ia] = va; end
    if (ib >= 0) begin bank0[ib] = vb; bank1[ib] = vb; end
    wr_addr0.delete(); wr_dat0.delete(); spk0.delete();
    wr_addr1.delete(); wr_dat1.delete();
  endtask

  // One scan on dut0; optional stall of the first spike and optional mid-scan start pulse.
  task automatic run_scan(input logic signed [15:0] th, input int stall, input int stall_idx,
                          input int inject_at, output int cyc);
    int  stall_left;
    bit  fin;
    stall_left = stall;
    busy_low   = 0;
    fin        = 1'b0;
    @(posedge clk); #1;
    start0  = 1'b1;
    thresh0 = th;
    ready0  = 1'b1;
    cyc     = 1;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == inject_at) begin
        start0  = 1'b1;
        thresh0 = 16'sd0;
      end else begin
        start0 = 1'b0;
      end
      if (!busy0) busy_low++;
      if (bus0.spike_valid && stall_left > 0) begin
        n_cmp++;
        if (bus0.spike_idx !== 4'(stall_idx)) begin
          n_err++;
          $display("FAIL stall_hold: spike_idx=%0d required %0d (stall left %0d)",
                   bus0.spike_idx, stall_idx, stall_left);
        end
        ready0 = 1'b0;
        stall_left--;
      end else begin
        ready0 = 1'b1;
      end
      if (done0) fin = 1'b1;
      else if (cyc > 300) begin
        n_cmp++; n_err++;
        $display("FAIL scan_timeout: no done after %0d cycles", cyc);
        fin = 1'b1;
      end
    end
    ready0 = 1'b1;
  endtask

  task automatic check_case1_result(input string tag, input int cyc, input int exp_cyc);
    n_cmp++;
    if (spk0.size() != 2) begin
      n_err++;
      $display("FAIL %s_spike_n: got %0d spikes required 2", tag, spk0.size());
    end else if (spk0[0] != 3 || spk0[1] != 9) begin
      n_err++;
      $display("FAIL %s_spike_idx: got %0d,%0d required 3,9", tag, spk0[0], spk0[1]);
    end
    n_cmp++;
    if (wr_addr0.size() != 2) begin
      n_err++;
      $display("FAIL %s_wr_n: got %0d writes required 2", tag, wr_addr0.size());
    end else if (wr_addr0[0] != 3 || wr_dat0[0] !== 16'sd50 ||
                 wr_addr0[1] != 9 || wr_dat0[1] !== 16'sd0) begin
      n_err++;
      $display("FAIL %s_wr: got [%0d]=%0d [%0d]=%0d required [3]=50 [9]=0", tag,
               wr_addr0[0], wr_dat0[0], wr_addr0[1], wr_dat0[1]);
    end
    n_cmp++;
    if (cnt0 !== 5'd2) begin
      n_err++;
      $display("FAIL %s_count: got %0d required 2", tag, cnt0);
    end
    n_cmp++;
    if (cyc != exp_cyc) begin
      n_err++;
      $display("FAIL %s_latency: done at cycle %0d required %0d", tag, cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, done0, bus0.mem_rd_en, bus0.mem_wr_en, bus0.mem_addr, bus0.mem_wr_data,
         bus0.spike_valid, bus0.spike_idx, cnt0} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_dut0: busy=%b done=%b rd=%b wr=%b addr=%0d wd=%0d vld=%b idx=%0d cnt=%0d required all 0",
               busy0, done0, bus0.mem_rd_en, bus0.mem_wr_en, bus0.mem_addr, bus0.mem_wr_data,
               bus0.spike_valid, bus0.spike_idx, cnt0);
    end
    n_cmp++;
    if ({busy1, done1, bus1.mem_rd_en, bus1.mem_wr_en, bus1.spike_valid, cnt1} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_dut1: busy=%b done=%b rd=%b wr=%b vld=%b cnt=%0d required all 0",
               busy1, done1, bus1.mem_rd_en, bus1.mem_wr_en, bus1.spike_valid, cnt1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fire();
    int cyc;
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    run_scan(16'sd100, 0, 0, 0, cyc);
    check_case1_result("basic", cyc, 36);
    n_cmp++;
    if (busy_low != 0) begin
      n_err++;
      $display("FAIL basic_busy: busy low in %0d scan cycles required 0", busy_low);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: done=%b busy=%b after DONE required 0,0", done0, busy0);
    end
  endtask

  task automatic test_no_fire();
    int cyc;
    load_banks(-16'sd5, -1, 16'sd0, -1, 16'sd0);
    run_scan(16'sd0, 0, 0, 0, cyc);
    n_cmp++;
    if (wr_addr0.size() != 0 || spk0.size() != 0 || cnt0 !== 5'd0) begin
      n_err++;
      $display("FAIL nofire_activity: writes=%0d spikes=%0d count=%0d required 0,0,0",
               wr_addr0.size(), spk0.size(), cnt0);
    end
    n_cmp++;
    if (cyc != 34) begin
      n_err++;
      $display("FAIL nofire_latency: done at cycle %0d required 34", cyc);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    load_banks(16'sd0, 0, -16'sd32768, -1, 16'sd0);
    run_scan(16'sd1, 0, 0, 0, cyc);
    n_cmp++;
    if (spk0.size() != 0 || wr_addr0.size() != 0) begin
      n_err++;
      $display("FAIL min_v_nofire: spikes=%0d writes=%0d required 0,0", spk0.size(), wr_addr0.size());
    end
    // Threshold at the most negative value: every neuron fires, count reaches 16.
    load_banks(16'sd0, 5, 16'sd32767, -1, 16'sd0);
    run_scan(-16'sd32768, 0, 0, 0, cyc);
    n_cmp++;
    if (cnt0 !== 5'd16 || spk0.size() != 16) begin
      n_err++;
      $display("FAIL min_thr_count: count=%0d spikes=%0d required 16,16", cnt0, spk0.size());
    end
    n_cmp++;
    if (wr_addr0.size() != 16) begin
      n_err++;
      $display("FAIL min_thr_wr_n: writes=%0d required 16", wr_addr0.size());
    end else if (wr_addr0[5] != 5 || wr_dat0[5] !== 16'sd32767 || wr_dat0[0] !== 16'sd32767) begin
      n_err++;
      $display("FAIL min_thr_sat: [%0d]=%0d [0]=%0d required [5]=32767 [0]=32767",
               wr_addr0[5], wr_dat0[5], wr_dat0[0]);
    end
    n_cmp++;
    if (cyc != 50) begin
      n_err++;
      $display("FAIL min_thr_latency: done at cycle %0d required 50", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    run_scan(16'sd100, 5, 3, 0, cyc);
    check_case1_result("stall", cyc, 41);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    run_scan(16'sd100, 0, 0, 10, cyc);
    check_case1_result("restart_ignored", cyc, 36);
  endtask

  task automatic test_reset_mid_scan();
    int  cyc;
    bit  found;
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    found = 1'b0;
    @(posedge clk); #1;
    start0  = 1'b1;
    thresh0 = 16'sd100;
    ready0  = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      if (bus0.spike_valid && bus0.spike_idx == 4'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rst_reach_emit: spike 3 not offered within 100 cycles");
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy0, done0, bus0.mem_rd_en, bus0.mem_wr_en, bus0.mem_addr, bus0.mem_wr_data,
         bus0.spike_valid, bus0.spike_idx, cnt0} !== 34'd0) begin
      n_err++;
      $display("FAIL rst_async: busy=%b vld=%b idx=%0d addr=%0d cnt=%0d required all 0",
               busy0, bus0.spike_valid, bus0.spike_idx, bus0.mem_addr, cnt0);
    end
    ready0 = 1'b1;
    wr_addr0.delete(); wr_dat0.delete(); spk0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_addr0.size() != 0 || spk0.size() != 0 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_resume: writes=%0d spikes=%0d busy=%b required 0,0,0",
               wr_addr0.size(), spk0.size(), busy0);
    end
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    run_scan(16'sd100, 0, 0, 0, cyc);
    check_case1_result("rescan", cyc, 36);
  endtask

  task automatic test_reset_to_zero_mode();
    bit fin;
    load_banks(16'sd50, 3, 16'sd150, 9, 16'sd100);
    fin = 1'b0;
    @(posedge clk); #1;
    start1  = 1'b1;
    thresh1 = 16'sd100;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) fin = 1'b1;
    end
    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL mode1_timeout: no done within 200 cycles");
    end
    n_cmp++;
    if (wr_addr1.size() != 2) begin
      n_err++;
      $display("FAIL mode1_wr_n: writes=%0d required 2", wr_addr1.size());
    end else if (wr_addr1[0] != 3 || wr_dat1[0] !== 16'sd0 ||
                 wr_addr1[1] != 9 || wr_dat1[1] !== 16'sd0) begin
      n_err++;
      $display("FAIL mode1_wr: [%0d]=%0d [%0d]=%0d required [3]=0 [9]=0",
               wr_addr1[0], wr_dat1[0], wr_addr1[1], wr_dat1[1]);
    end
    n_cmp++;
    if (cnt1 !== 5'd2) begin
      n_err++;
      $display("FAIL mode1_count: got %0d required 2", cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fire();
    test_no_fire();
    test_extremes();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_scan();
    test_reset_to_zero_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
